llr_load_ctrl: RTL and testbench

Controller that sequences the 1024×8 LLR shift buffer. It accepts a frame of channel LLRs as 64-bit words over a valid/ready handshake and drives the buffer's shift-in write port. It tells the decoder when a complete frame is resident, then serves single-LLR reads by logical index, translating each index to the buffer's physical shift position. It sits between the channel input stage and the decoder core and owns the buffer's write-enable and read-position inputs.

---
 rtl/llr_load_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_llr_load_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_load_ctrl.sv
// ---------------------------------------------------------------------------
// llr_load_ctrl
// Sequences a 1024x8 LLR shift buffer: loads a frame of channel LLRs (eight per
// 64-bit word) over a valid/ready handshake, flags when the whole frame is
// resident, then serves single-LLR reads by logical (arrival-order) index,
// translating each index to the buffer's physical shift position.
//
// Optional feature: define LLR_CTRL_CLIP_EN to saturate every signed input byte
// to [-CLIP_MAG, +CLIP_MAG] on its way into the buffer.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_frame_len         frame size code (0:256, 1:512, 2/3:1024 LLRs)
//   i_in_valid/o_in_ready/i_in_data   input word handshake
//   o_mem_wen/o_mem_data              buffer shift-in port
//   o_mem_pos/i_mem_data              buffer read position / read data
//   o_frame_rdy         complete frame resident
//   i_rd_req/i_rd_idx   decoder read request, logical index
//   o_rd_valid/o_rd_data/o_rd_err     read response (1-cycle latency)
//   i_frame_done        decoder releases the frame
// ---------------------------------------------------------------------------
module llr_load_ctrl #(
  parameter int unsigned CLIP_MAG = 127
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_frame_len,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_data,
  output logic        o_mem_wen,
  output logic [63:0] o_mem_data,
  output logic [9:0]  o_mem_pos,
  input  logic [7:0]  i_mem_data,
  output logic        o_frame_rdy,
  input  logic        i_rd_req,
  input  logic [9:0]  i_rd_idx,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_err,
  input  logic        i_frame_done
);

  localparam int unsigned LLR_W  = 8;
  localparam int unsigned LANES  = 8;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned EXT_W  = LLR_W + 1;

`ifdef LLR_CTRL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [LEN_W-1:0]   n_len, n_len_nxt;
  logic [CNT_W-1:0]   m_words;
  logic               accept;

  logic               rd_hit;
  logic               rd_in_range;
  logic [LEN_W-1:0]   pos_full;

  // Frame-length code to LLR count; code 3 aliases 1024.
  function automatic logic [LEN_W-1:0] len_decode(input logic [1:0] code);
    case (code)
      2'd0:    len_decode = LEN_W'(256);
      2'd1:    len_decode = LEN_W'(512);
      default: len_decode = LEN_W'(1024);
    endcase
  endfunction

  // Words per frame (N/8, at most 128).
  assign m_words = CNT_W'(n_len >> 3);
  assign accept  = i_in_valid & o_in_ready;

  // State, word counter and latched frame length.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      count <= '0;
      n_len <= LEN_W'(1024);
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      n_len <= n_len_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    n_len_nxt = n_len;
    case (state)
      S_IDLE: begin
        if (accept) begin
          n_len_nxt = len_decode(i_frame_len);
          count_nxt = CNT_W'(1);
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (count + CNT_W'(1) == m_words) begin
            count_nxt = '0;
            state_nxt = S_READY;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      S_READY: begin
        if (i_frame_done) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_in_ready  = 1'b0;
    o_frame_rdy = 1'b0;
    case (state)
      S_IDLE:  o_in_ready  = 1'b1;
      S_LOAD:  o_in_ready  = 1'b1;
      S_READY: o_frame_rdy = 1'b1;
      default: o_in_ready  = 1'b0;
    endcase
  end

  // Shift-in happens on the same edge as the accept.
  assign o_mem_wen = accept;

  // Optional per-byte symmetric saturation of the write data.
  localparam logic signed [EXT_W-1:0] MAG_POS = EXT_W'(CLIP_MAG);
  localparam logic signed [EXT_W-1:0] MAG_NEG = -MAG_POS;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [LLR_W-1:0]        raw;
    logic [LLR_W-1:0]        sat;
    logic signed [EXT_W-1:0] ext;

    assign raw = i_in_data[j*LLR_W +: LLR_W];
    assign ext = $signed({raw[LLR_W-1], raw});

    always_comb begin
      sat = raw;
      if (ext > MAG_POS)      sat = LLR_W'(MAG_POS);
      else if (ext < MAG_NEG) sat = LLR_W'(MAG_NEG);
    end

    assign o_mem_data[j*LLR_W +: LLR_W] = CLIP_EN ? sat : raw;
  end

  // Newest word sits at positions 0..7, so word k>>3 is (M-1-(k>>3)) words deep.
  assign rd_hit      = (state == S_READY) & i_rd_req;
  assign rd_in_range = LEN_W'(i_rd_idx) < n_len;
  assign pos_full    = n_len - LEN_W'(8)
                     - LEN_W'(i_rd_idx & ~POS_W'(7))
                     + LEN_W'(i_rd_idx &  POS_W'(7));

  // Read pipeline: position and response flags registered on the request edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_pos  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_err   <= 1'b0;
    end else begin
      o_rd_valid <= rd_hit;
      o_rd_err   <= rd_hit & ~rd_in_range;
      if (rd_hit && rd_in_range) o_mem_pos <= pos_full[POS_W-1:0];
    end
  end

  // Buffer read data is combinational from o_mem_pos; forced to 0 otherwise.
  assign o_rd_data = (o_rd_valid & ~o_rd_err) ? i_mem_data : '0;

endmodule

// File: tb/tb_llr_load_ctrl.sv
module tb_llr_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  frame_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        mem_wen;
  logic [63:0] mem_data;
  logic [9:0]  mem_pos;
  logic [7:0]  mem_rdata;
  logic        frame_rdy;
  logic        rd_req;
  logic [9:0]  rd_idx;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_err;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [9:0] pos;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sent[1024];
  logic [7:0] mem[1024];
  int         cur_n;
  logic [9:0] last_pos;

  llr_load_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_frame_len (frame_len),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_mem_wen   (mem_wen),
    .o_mem_data  (mem_data),
    .o_mem_pos   (mem_pos),
    .i_mem_data  (mem_rdata),
    .o_frame_rdy (frame_rdy),
    .i_rd_req    (rd_req),
    .i_rd_idx    (rd_idx),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_rd_err    (rd_err),
    .i_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1024x8 shift buffer: newest word enters at positions 0..7.
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int i = 1023; i >= 8; i--) mem[i] <= mem[i-8];
      for (int j = 0; j < 8; j++) mem[j] <= mem_data[8*j +: 8];
    end
  end
  assign mem_rdata = mem[mem_pos];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each valid response.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_latency", 64'(cyc), 64'(e.cyc));
          check("rsp_data", rd_data, e.data);
          check("rsp_err", rd_err, e.err);
          check("rsp_pos", mem_pos, e.pos);
        end
      end else begin
        check("idle_rd_data", rd_data, 8'h00);
      end
    end
  end

  // Drive a read for one cycle and record its expected response.
  task automatic issue_rd(input int k);
    exp_t e;
    rd_req = 1'b1;
    rd_idx = 10'(k);
    if (k < cur_n) begin
      e.data   = sent[k];
      e.err    = 1'b0;
      e.pos    = 10'(8 * (cur_n / 8 - 1 - (k / 8)) + (k % 8));
      last_pos = e.pos;
    end else begin
      e.data = 8'h00;
      e.err  = 1'b1;
      e.pos  = last_pos;
    end
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Send words first..(n/8 - 1) of a frame whose byte j of word w is 8w+j.
  task automatic load_words(input logic [1:0] code, input int n, input int first);
    frame_len = code;
    for (int w = first; w < n / 8; w++) begin
      in_valid = 1'b1;
      for (int j = 0; j < 8; j++) begin
        in_data[8*j +: 8] = 8'(8 * w + j);
        sent[8*w+j]       = 8'(8 * w + j);
      end
      if (w == n / 8 - 1) begin
        #2 check("frame_rdy_before_last", frame_rdy, 1'b0);
      end
      @(posedge clk); #1;
      frame_len = ~code;
    end
    in_valid = 1'b0;
    cur_n    = n;
    check("frame_rdy_after_last", frame_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] clip_word;
    rst = 1'b1; frame_len = 2'd0; in_valid = 1'b0; in_data = '0;
    rd_req = 1'b0; rd_idx = '0; frame_done = 1'b0;
    cur_n = 1024; last_pos = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_rdy", frame_rdy, 1'b0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_mem_pos", mem_pos, 10'd0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Write-data path (no accept: valid held low).
    clip_word = 64'h0000_0000_0000_7F80;
    in_data = clip_word;
    #1;
`ifdef LLR_CTRL_CLIP_EN
    check("clip_0x80", mem_data[7:0], 8'h81);
`else
    check("clip_0x80", mem_data[7:0], 8'h80);
`endif
    check("clip_0x7f", mem_data[15:8], 8'h7F);
    check("idle_no_wen", mem_wen, 1'b0);

    // Reads and frame_done outside READY are ignored.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_idx = 10'd3; frame_done = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0; frame_done = 1'b0;
    @(posedge clk); #1;
    check("idle_still_ready", in_ready, 1'b1);

    // 256-LLR frame with a few single reads.
    load_words(2'd0, 256, 0);
    check("ready_in_ready", in_ready, 1'b0);
    issue_rd(0);
    rd_req = 1'b0; @(posedge clk); #1;
    issue_rd(9);
    issue_rd(255);
    issue_rd(300);
    rd_req = 1'b0; @(posedge clk); #1;
    check("oor_pos_kept", mem_pos, 10'd7);

    // Backpressure in READY, then release with a simultaneous read.
    frame_len = 2'd2;
    in_valid  = 1'b1;
    for (int j = 0; j < 8; j++) in_data[8*j +: 8] = 8'(j);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_mem_wen", mem_wen, 1'b0);
      @(posedge clk); #1;
    end
    frame_done = 1'b1;
    issue_rd(5);
    frame_done = 1'b0;
    rd_req     = 1'b0;
    check("rel_frame_rdy", frame_rdy, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_mem_wen", mem_wen, 1'b1);
    for (int j = 0; j < 8; j++) sent[j] = 8'(j);
    @(posedge clk); #1;

    // Rest of a 1024-LLR frame, then fully pipelined reads of every index.
    load_words(2'd2, 1024, 1);
    for (int k = 0; k < 1024; k++) issue_rd(k);
    rd_req = 1'b0;
    @(posedge clk); #1;
    check("pos_1023", mem_pos, 10'd7);
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    check("done_idle", in_ready, 1'b1);

    // Asynchronous reset in the middle of a 256-LLR load.
    frame_len = 2'd0;
    in_valid  = 1'b1;
    for (int w = 0; w < 10; w++) begin
      in_data = {8{8'(w)}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midload_in_ready", in_ready, 1'b1);
    check("midload_frame_rdy", frame_rdy, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    load_words(2'd0, 256, 0);
    issue_rd(17);
    issue_rd(128);
    rd_req = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while a response is pending.
    issue_rd(1);
    rd_req = 1'b0;
    rst = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    #1;
    check("midread_rd_valid", rd_valid, 1'b0);
    check("midread_frame_rdy", frame_rdy, 1'b0);
    #1 rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
